frame_buf_arbiter: RTL and testbench
====================================

Name: frame_buf_arbiter

Overview:
- Single-clock, parametrised frame-buffer index arbiter for the video base-address loop.
- Manages NBUF frame buffers in external memory, shared by one writer and RDPORT readers.
- Each writer vsync commits the finished frame and allocates a free buffer.
- Each reader vsync latches the latest committed frame. The arbiter never hands the writer a buffer that a reader holds, and it counts dropped frames.
- Generalises the fixed triple-buffer, three-reader mapper to N buffers, R ports, per-port enable and drop statistics.
- Reader vsyncs are already synchronised into pclk by their sources.

Parameters:
NBUF, 4, number of frame buffers; elaboration error unless NBUF >= RDPORT+2
RDPORT, 3, number of read ports
ASIZE, 32, address width
BASE, 32'h1000_0000, address of buffer 0
FRAME_BYTES, 32'h0010_0000, stride between buffers
CSIZE, 16, drop counter width

Ports:
pclk  in  1  clock
rst  in  1  asynchronous, active-high reset
wr_vs  in  1  writer vsync, pclk-synchronous
rd_vs  in  RDPORT  reader vsyncs, pclk-synchronous
rd_en  in  RDPORT  reader enable; 0 = port idle, holds no buffer
wr_base  out  ASIZE  base address the writer fills
wr_idx  out  clog2(NBUF)  buffer index for wr_base
rd_base  out  RDPORT*ASIZE  per-port read base address, port r at [r*ASIZE +: ASIZE]
rd_valid  out  RDPORT  port holds a committed frame
rd_new  out  RDPORT  1-cycle pulse: port latched a frame it had not read before
drop_cnt  out  CSIZE  saturating count of committed frames overwritten unread

Behaviour:
- Reset (async assert, release sync to pclk):
  - wr_idx=0, last_idx=0, last_valid=0, last_read=0, wr_active=0.
  - All rd_idx=0, rd_valid=0, rd_new=0, drop_cnt=0.
  - wr_base=BASE, all rd_base=BASE.
  - Reset mid-frame discards all state; no drop is counted.
- Edge detect: vs registered twice; rise = vs_r & ~vs_rr.
  - State updates at the pclk edge after rise is seen, i.e. 1 clock after the edge that first samples vs high.
  - All outputs are registered.
- Writer rise, wr_active=0: set wr_active=1. No commit, wr_idx unchanged.
- Writer rise, wr_active=1:
  - If last_valid & ~last_read, then drop_cnt++ (saturates at all-ones).
  - last_idx<=wr_idx, last_valid<=1, last_read<=0.
  - New wr_idx = lowest index not equal to the new last_idx and not equal to any rd_idx_next[r] with rd_valid_next[r]=1. rd_*_next are the post-update reader values of the same cycle.
  - The NBUF >= RDPORT+2 rule guarantees a free buffer exists.
- Reader rise on port r with rd_en[r]=1:
  - Source is the forwarded last: if a writer commit occurs in the same cycle, use the newly committed wr_idx, otherwise last_idx.
  - If the forwarded last_valid=1: rd_idx[r]<=source, rd_valid[r]<=1, last_read<=1.
  - rd_new[r]=1 for one cycle if the index differs from the previous rd_idx[r] or rd_valid[r] was 0.
  - Otherwise (same frame repeated) rd_new[r]=0.
  - If no frame is committed yet: no change, rd_valid stays 0.
- rd_en[r]=0: rd_valid[r]<=0 next cycle, releasing its buffer for allocation. Rises on that port are ignored. rd_idx[r] is held, so rd_base is unchanged but invalid.
- Several ports rising in the same cycle all latch the same frame.
- Address arithmetic: base = BASE + idx*FRAME_BYTES, computed in ASIZE bits; wraps modulo 2^ASIZE with no error.

Decomposition:
- Package fba_pkg holds:
  - idx_t = logic [clog2(NBUF)-1:0];
  - function idx2addr(idx, BASE, FRAME_BYTES);
  - function pick_free(excl_mask) returning the lowest clear bit.
- Sub-module vs_rise_det: 2-flop register plus rise pulse, with async active-high reset. It is instantiated 1+RDPORT times.

Test Plan:
All scenarios use the defaults (NBUF=4, RDPORT=3, BASE=0x1000_0000, FRAME_BYTES=0x0010_0000).
- Reset, then idle: wr_base=0x1000_0000, rd_base[0..2]=0x1000_0000, rd_valid=000, drop_cnt=0; rst asserted mid-frame restores the same values immediately.
- wr_vs rise 1 then rise 2: after rise 1 wr_idx=0; after rise 2 last=0 and wr_idx=1, so wr_base=0x1010_0000, 1 clock after rise detect.
- rd_vs[0] rise, then wr_vs rise 3: rd_base[0]=0x1000_0000, rd_valid[0]=1, rd_new[0] pulses 1 cycle; the commit sets last=1 and allocates wr_idx=2 (0 held, 1 last).
- wr_vs rise and rd_vs[1] rise in the same cycle, wr_idx=2: reader 1 gets idx 2 (rd_base[1]=0x1020_0000); next wr_idx excludes 0 and 2, so wr_idx=1.
- Two further wr_vs rises with no reader vsync: drop_cnt increments by exactly 1; forcing 2^CSIZE+5 drops leaves drop_cnt=0xFFFF.
- rd_en[0]=0 while port 0 holds idx 0, then wr_vs rise: rd_valid[0]=0 and idx 0 becomes allocatable (wr_idx=0 when it is the lowest free); a rd_vs[0] rise while disabled causes no change.

Source files
------------

// File: rtl/fba_pkg.sv
// rtl/fba_pkg.sv - shared types and helpers for the frame-buffer index arbiter
package fba_pkg;

  localparam int MAX_NBUF = 64;
  localparam int MAX_IW   = 6;
  localparam int MAX_AW   = 64;

  typedef logic [MAX_IW-1:0] idx_t;

  // Buffer base address; callers keep the low ASIZE bits, so wrap is modulo 2^ASIZE.
  function automatic logic [MAX_AW-1:0] idx2addr(input idx_t idx,
                                                 input logic [MAX_AW-1:0] base,
                                                 input logic [MAX_AW-1:0] stride);
    return base + stride * MAX_AW'(idx);
  endfunction

  function automatic idx_t pick_free(input logic [MAX_NBUF-1:0] excl_mask);
    idx_t res;
    res = '0;
    for (int i = MAX_NBUF - 1; i >= 0; i--) begin
      if (!excl_mask[i]) res = idx_t'(i);
    end
    return res;
  endfunction

endpackage

// File: rtl/frame_buf_arbiter_vs_rise_det.sv
// rtl/frame_buf_arbiter_vs_rise_det.sv - two-flop vsync register with rising-edge pulse
module vs_rise_det (
  input  logic clk_i,
  input  logic rst_i,
  input  logic vs_i,
  output logic rise_o
);

  logic vs_r_q;
  logic vs_rr_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      vs_r_q  <= 1'b0;
      vs_rr_q <= 1'b0;
    end else begin
      vs_r_q  <= vs_i;
      vs_rr_q <= vs_r_q;
    end
  end

  assign rise_o = vs_r_q & ~vs_rr_q;

endmodule

// File: rtl/frame_buf_arbiter.sv
// rtl/frame_buf_arbiter.sv - N-buffer writer/reader frame index arbiter with drop counting
module frame_buf_arbiter
  import fba_pkg::*;
#(
  parameter int               NBUF        = 4,
  parameter int               RDPORT      = 3,
  parameter int               ASIZE       = 32,
  parameter logic [ASIZE-1:0] BASE        = 32'h1000_0000,
  parameter logic [ASIZE-1:0] FRAME_BYTES = 32'h0010_0000,
  parameter int               CSIZE       = 16,
  localparam int              IW          = (NBUF > 1) ? $clog2(NBUF) : 1
) (
  input  logic                    pclk,
  input  logic                    rst,
  input  logic                    wr_vs,
  input  logic [RDPORT-1:0]       rd_vs,
  input  logic [RDPORT-1:0]       rd_en,
  output logic [ASIZE-1:0]        wr_base,
  output logic [IW-1:0]           wr_idx,
  output logic [RDPORT*ASIZE-1:0] rd_base,
  output logic [RDPORT-1:0]       rd_valid,
  output logic [RDPORT-1:0]       rd_new,
  output logic [CSIZE-1:0]        drop_cnt
);

  if (NBUF < RDPORT + 2) begin : g_nbuf_chk
    $error("frame_buf_arbiter: NBUF must be >= RDPORT+2");
  end
  if (NBUF > MAX_NBUF || ASIZE > MAX_AW) begin : g_size_chk
    $error("frame_buf_arbiter: NBUF or ASIZE exceeds package limits");
  end

  logic              wr_rise;
  logic [RDPORT-1:0] rd_rise;

  vs_rise_det u_wr_det (.clk_i(pclk), .rst_i(rst), .vs_i(wr_vs), .rise_o(wr_rise));

  for (genvar g = 0; g < RDPORT; g++) begin : g_rd_det
    vs_rise_det u_rd_det (.clk_i(pclk), .rst_i(rst), .vs_i(rd_vs[g]), .rise_o(rd_rise[g]));
  end

  logic [IW-1:0]           wr_idx_q, wr_idx_d, last_idx_q, last_idx_d;
  logic                    last_valid_q, last_valid_d, last_read_q, last_read_d;
  logic                    wr_active_q, wr_active_d;
  logic [IW-1:0]           rd_idx_q [RDPORT];
  logic [IW-1:0]           rd_idx_d [RDPORT];
  logic [RDPORT-1:0]       rd_valid_q, rd_valid_d, rd_new_q, rd_new_d;
  logic [CSIZE-1:0]        drop_q, drop_d;
  logic [ASIZE-1:0]        wr_base_q, wr_base_d;
  logic [RDPORT*ASIZE-1:0] rd_base_q, rd_base_d;

  logic                    commit, fwd_valid, any_read;
  logic [IW-1:0]           fwd_idx;
  logic [MAX_NBUF-1:0]     excl;

  always_comb begin
    commit      = wr_rise & wr_active_q;
    wr_active_d = wr_active_q | wr_rise;
    // Readers rising with a commit see the frame being committed this cycle.
    fwd_valid   = commit | last_valid_q;
    fwd_idx     = commit ? wr_idx_q : last_idx_q;
    any_read    = 1'b0;
    rd_new_d    = '0;
    rd_valid_d  = rd_valid_q & rd_en;
    for (int r = 0; r < RDPORT; r++) begin
      rd_idx_d[r] = rd_idx_q[r];
      if (rd_en[r] && rd_rise[r] && fwd_valid) begin
        rd_idx_d[r]   = fwd_idx;
        rd_valid_d[r] = 1'b1;
        rd_new_d[r]   = !rd_valid_q[r] || (rd_idx_q[r] != fwd_idx);
        any_read      = 1'b1;
      end
    end

    for (int i = 0; i < MAX_NBUF; i++) excl[i] = (i >= NBUF);
    excl[wr_idx_q] = 1'b1;
    for (int r = 0; r < RDPORT; r++) begin
      if (rd_valid_d[r]) excl[rd_idx_d[r]] = 1'b1;
    end

    last_idx_d   = last_idx_q;
    last_valid_d = last_valid_q;
    last_read_d  = last_read_q | any_read;
    drop_d       = drop_q;
    wr_idx_d     = wr_idx_q;
    if (commit) begin
      if (last_valid_q && !last_read_q && !(&drop_q)) drop_d = drop_q + CSIZE'(1);
      last_idx_d   = wr_idx_q;
      last_valid_d = 1'b1;
      last_read_d  = any_read;
      wr_idx_d     = IW'(pick_free(excl));
    end

    wr_base_d = ASIZE'(idx2addr(idx_t'(wr_idx_d), MAX_AW'(BASE), MAX_AW'(FRAME_BYTES)));
    rd_base_d = '0;
    for (int r = 0; r < RDPORT; r++) begin
      rd_base_d[r*ASIZE +: ASIZE] =
        ASIZE'(idx2addr(idx_t'(rd_idx_d[r]), MAX_AW'(BASE), MAX_AW'(FRAME_BYTES)));
    end
  end

  always_ff @(posedge pclk or posedge rst) begin
    if (rst) begin
      wr_idx_q     <= '0;
      last_idx_q   <= '0;
      last_valid_q <= 1'b0;
      last_read_q  <= 1'b0;
      wr_active_q  <= 1'b0;
      for (int r = 0; r < RDPORT; r++) rd_idx_q[r] <= '0;
      rd_valid_q   <= '0;
      rd_new_q     <= '0;
      drop_q       <= '0;
      wr_base_q    <= BASE;
      rd_base_q    <= {RDPORT{BASE}};
    end else begin
      wr_idx_q     <= wr_idx_d;
      last_idx_q   <= last_idx_d;
      last_valid_q <= last_valid_d;
      last_read_q  <= last_read_d;
      wr_active_q  <= wr_active_d;
      for (int r = 0; r < RDPORT; r++) rd_idx_q[r] <= rd_idx_d[r];
      rd_valid_q   <= rd_valid_d;
      rd_new_q     <= rd_new_d;
      drop_q       <= drop_d;
      wr_base_q    <= wr_base_d;
      rd_base_q    <= rd_base_d;
    end
  end

  assign wr_idx   = wr_idx_q;
  assign wr_base  = wr_base_q;
  assign rd_base  = rd_base_q;
  assign rd_valid = rd_valid_q;
  assign rd_new   = rd_new_q;
  assign drop_cnt = drop_q;

endmodule

// File: tb/tb_frame_buf_arbiter.sv
// tb/tb_frame_buf_arbiter.sv - self-checking bench for frame_buf_arbiter
module tb_frame_buf_arbiter;

  localparam int NB = 4;

  logic        pclk = 1'b0;
  logic        rst = 1'b1;
  logic        wr_vs = 1'b0;
  logic [2:0]  rd_vs = '0;
  logic [2:0]  rd_en = 3'b111;
  logic [31:0] wr_base, wr_base_s;
  logic [1:0]  wr_idx, wr_idx_s;
  logic [95:0] rd_base, rd_base_s;
  logic [2:0]  rd_valid, rd_valid_s, rd_new, rd_new_s;
  logic [15:0] drop_cnt;
  logic [3:0]  drop_cnt_s;

  frame_buf_arbiter dut (
    .pclk(pclk), .rst(rst), .wr_vs(wr_vs), .rd_vs(rd_vs), .rd_en(rd_en),
    .wr_base(wr_base), .wr_idx(wr_idx), .rd_base(rd_base), .rd_valid(rd_valid),
    .rd_new(rd_new), .drop_cnt(drop_cnt)
  );

  frame_buf_arbiter #(.CSIZE(4)) dut_s (
    .pclk(pclk), .rst(rst), .wr_vs(wr_vs), .rd_vs(rd_vs), .rd_en(rd_en),
    .wr_base(wr_base_s), .wr_idx(wr_idx_s), .rd_base(rd_base_s), .rd_valid(rd_valid_s),
    .rd_new(rd_new_s), .drop_cnt(drop_cnt_s)
  );

  always #5 pclk = ~pclk;

  int n_checks = 0;
  int n_fail = 0;

  // Reference model: frame ownership in plain integers.
  bit       m_active, m_lv, m_lr;
  int       m_last, m_wr, m_drop;
  int       m_ri [3];
  bit [2:0] m_rv, m_en, exp_new;
  logic [1:0] pre_wr_idx;

  function automatic logic [31:0] addr(input int i);
    return 32'h1000_0000 + 32'(i) * 32'h0010_0000;
  endfunction

  task automatic model_reset();
    m_active = 0; m_lv = 0; m_lr = 0; m_last = 0; m_wr = 0; m_drop = 0;
    m_rv = '0; exp_new = '0;
    for (int r = 0; r < 3; r++) m_ri[r] = 0;
  endtask

  task automatic model_event(input bit w, input bit [2:0] rm);
    bit commit, src_v, rd_any, held;
    int src;
    commit = w && m_active;
    if (w) m_active = 1;
    src_v  = commit || m_lv;
    src    = commit ? m_wr : m_last;
    rd_any = 0;
    exp_new = '0;
    for (int r = 0; r < 3; r++) begin
      if (m_en[r] && rm[r] && src_v) begin
        exp_new[r] = !m_rv[r] || (m_ri[r] != src);
        m_ri[r] = src;
        m_rv[r] = 1;
        rd_any = 1;
      end
    end
    if (commit) begin
      if (m_lv && !m_lr) m_drop++;
      m_last = src; m_lv = 1; m_lr = rd_any;
      m_wr = -1;
      for (int i = NB - 1; i >= 0; i--) begin
        held = (i == m_last);
        for (int r = 0; r < 3; r++) if (m_rv[r] && m_ri[r] == i) held = 1;
        if (!held) m_wr = i;
      end
    end else if (rd_any) begin
      m_lr = 1;
    end
  endtask

  // One vsync pulse; returns at the negedge after the state-update edge.
  task automatic pulse(input bit w, input bit [2:0] rm);
    @(posedge pclk); #1;
    wr_vs = w; rd_vs = rm;
    @(posedge pclk); #1;
    wr_vs = 0; rd_vs = '0;
    @(negedge pclk);
    pre_wr_idx = wr_idx;
    @(posedge pclk);
    @(negedge pclk);
    model_event(w, rm);
  endtask

  task automatic set_en(input bit [2:0] en);
    @(posedge pclk); #1;
    rd_en = en;
    m_en = en;
    @(posedge pclk);
    @(negedge pclk);
    m_rv = m_rv & en;
  endtask

  task automatic test_reset();
    rst = 1; rd_en = 3'b111; m_en = 3'b111;
    model_reset();
    repeat (3) @(posedge pclk);
    #1 rst = 0;
    repeat (3) @(negedge pclk);
    n_checks++; if (wr_base !== 32'h1000_0000) begin n_fail++; $display("FAIL reset_wr_base: got %h want 10000000", wr_base); end
    n_checks++; if (wr_idx !== 2'd0) begin n_fail++; $display("FAIL reset_wr_idx: got %0d want 0", wr_idx); end
    for (int r = 0; r < 3; r++) begin
      n_checks++; if (rd_base[r*32 +: 32] !== 32'h1000_0000) begin n_fail++; $display("FAIL reset_rd_base%0d: got %h want 10000000", r, rd_base[r*32 +: 32]); end
    end
    n_checks++; if (rd_valid !== 3'b000) begin n_fail++; $display("FAIL reset_rd_valid: got %b want 000", rd_valid); end
    n_checks++; if (drop_cnt !== 16'd0) begin n_fail++; $display("FAIL reset_drop: got %0d want 0", drop_cnt); end
  endtask

  task automatic test_first_commit();
    pulse(1, 3'b000);
    n_checks++; if (wr_idx !== 2'd0) begin n_fail++; $display("FAIL rise1_wr_idx: got %0d want 0", wr_idx); end
    pulse(1, 3'b000);
    n_checks++; if (pre_wr_idx !== 2'd0) begin n_fail++; $display("FAIL rise2_latency: got %0d want 0 before update edge", pre_wr_idx); end
    n_checks++; if (wr_idx !== 2'd1) begin n_fail++; $display("FAIL rise2_wr_idx: got %0d want 1", wr_idx); end
    n_checks++; if (wr_base !== 32'h1010_0000) begin n_fail++; $display("FAIL rise2_wr_base: got %h want 10100000", wr_base); end
  endtask

  task automatic test_reader_latch();
    pulse(0, 3'b001);
    n_checks++; if (rd_base[31:0] !== 32'h1000_0000) begin n_fail++; $display("FAIL rd0_base: got %h want 10000000", rd_base[31:0]); end
    n_checks++; if (rd_valid !== 3'b001) begin n_fail++; $display("FAIL rd0_valid: got %b want 001", rd_valid); end
    n_checks++; if (rd_new !== 3'b001) begin n_fail++; $display("FAIL rd0_new: got %b want 001", rd_new); end
    @(negedge pclk);
    n_checks++; if (rd_new !== 3'b000) begin n_fail++; $display("FAIL rd0_new_pulse: got %b want 000", rd_new); end
    pulse(1, 3'b000);
    n_checks++; if (wr_idx !== 2'd2) begin n_fail++; $display("FAIL rise3_wr_idx: got %0d want 2", wr_idx); end
  endtask

  task automatic test_same_cycle();
    pulse(1, 3'b010);
    n_checks++; if (rd_base[63:32] !== 32'h1020_0000) begin n_fail++; $display("FAIL fwd_rd1_base: got %h want 10200000", rd_base[63:32]); end
    n_checks++; if (rd_valid !== 3'b011) begin n_fail++; $display("FAIL fwd_rd_valid: got %b want 011", rd_valid); end
    n_checks++; if (wr_idx !== 2'd1) begin n_fail++; $display("FAIL fwd_wr_idx: got %0d want 1", wr_idx); end
  endtask

  task automatic test_drop();
    pulse(1, 3'b000);
    n_checks++; if (drop_cnt !== 16'(m_drop)) begin n_fail++; $display("FAIL drop_a: got %0d want %0d", drop_cnt, m_drop); end
    pulse(1, 3'b000);
    n_checks++; if (drop_cnt !== 16'd2) begin n_fail++; $display("FAIL drop_b: got %0d want 2", drop_cnt); end
  endtask

  task automatic test_disable();
    set_en(3'b110);
    n_checks++; if (rd_valid !== 3'b010) begin n_fail++; $display("FAIL dis_valid: got %b want 010", rd_valid); end
    n_checks++; if (rd_base[31:0] !== 32'h1000_0000) begin n_fail++; $display("FAIL dis_base_held: got %h want 10000000", rd_base[31:0]); end
    pulse(0, 3'b001);
    n_checks++; if (rd_valid !== 3'b010 || rd_new !== 3'b000) begin n_fail++; $display("FAIL dis_rise_ignored: got valid %b new %b want 010 000", rd_valid, rd_new); end
    pulse(1, 3'b000);
    n_checks++; if (wr_idx !== 2'd0) begin n_fail++; $display("FAIL dis_realloc: got %0d want 0", wr_idx); end
    n_checks++; if (wr_base !== 32'h1000_0000) begin n_fail++; $display("FAIL dis_realloc_base: got %h want 10000000", wr_base); end
    set_en(3'b111);
  endtask

  task automatic test_reset_midframe();
    @(posedge pclk); #1;
    wr_vs = 1;
    @(posedge pclk); #1;
    wr_vs = 0; rst = 1;
    #1;
    n_checks++; if (wr_base !== 32'h1000_0000 || wr_idx !== 2'd0) begin n_fail++; $display("FAIL mid_rst_wr: got %h/%0d want 10000000/0", wr_base, wr_idx); end
    n_checks++; if (rd_base !== {3{32'h1000_0000}}) begin n_fail++; $display("FAIL mid_rst_rd_base: got %h", rd_base); end
    n_checks++; if (rd_valid !== 3'b000 || drop_cnt !== 16'd0) begin n_fail++; $display("FAIL mid_rst_state: got valid %b drop %0d want 000 0", rd_valid, drop_cnt); end
    model_reset();
    @(posedge pclk); #1 rst = 0;
    repeat (2) @(negedge pclk);
    n_checks++; if (wr_idx !== 2'd0 || drop_cnt !== 16'd0) begin n_fail++; $display("FAIL mid_rst_after: got idx %0d drop %0d want 0 0", wr_idx, drop_cnt); end
  endtask

  task automatic test_saturate();
    for (int k = 0; k < 23; k++) pulse(1, 3'b000);
    n_checks++; if (drop_cnt !== 16'd21) begin n_fail++; $display("FAIL sat_wide: got %0d want 21", drop_cnt); end
    n_checks++; if (drop_cnt_s !== 4'hF) begin n_fail++; $display("FAIL sat_narrow: got %0d want 15", drop_cnt_s); end
  endtask

  task automatic test_random();
    bit [2:0] ev;
    for (int k = 0; k < 80; k++) begin
      if ($urandom_range(0, 7) == 0) set_en(3'($urandom_range(0, 7)));
      pulse(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)));
      for (int r = 0; r < 3; r++) ev[r] = m_rv[r];
      n_checks++; if (wr_idx !== 2'(m_wr)) begin n_fail++; $display("FAIL rnd%0d_wr_idx: got %0d want %0d", k, wr_idx, m_wr); end
      n_checks++; if (wr_base !== addr(m_wr)) begin n_fail++; $display("FAIL rnd%0d_wr_base: got %h want %h", k, wr_base, addr(m_wr)); end
      for (int r = 0; r < 3; r++) begin
        n_checks++; if (rd_base[r*32 +: 32] !== addr(m_ri[r])) begin n_fail++; $display("FAIL rnd%0d_rd_base%0d: got %h want %h", k, r, rd_base[r*32 +: 32], addr(m_ri[r])); end
      end
      n_checks++; if (rd_valid !== ev) begin n_fail++; $display("FAIL rnd%0d_rd_valid: got %b want %b", k, rd_valid, ev); end
      n_checks++; if (rd_new !== exp_new) begin n_fail++; $display("FAIL rnd%0d_rd_new: got %b want %b", k, rd_new, exp_new); end
      n_checks++; if (drop_cnt !== 16'(m_drop)) begin n_fail++; $display("FAIL rnd%0d_drop: got %0d want %0d", k, drop_cnt, m_drop); end
      n_checks++; if (drop_cnt_s !== 4'((m_drop > 15) ? 15 : m_drop)) begin n_fail++; $display("FAIL rnd%0d_drop_sat: got %0d want %0d", k, drop_cnt_s, (m_drop > 15) ? 15 : m_drop); end
    end
  endtask

  initial begin
    test_reset();
    test_first_commit();
    test_reader_latch();
    test_same_cycle();
    test_drop();
    test_disable();
    test_reset_midframe();
    test_saturate();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
